// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Sequences 32-bit (or, with ALU_SEQ_WIDE_EN, two-pass 64-bit)
//            operations through an external combinational ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
   parameter int ZERO_IDLE_DRIVE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_sel,
   input  logic [63:0] cmd_a,
   input  logic [63:0] cmd_b,
   input  logic        cmd_cin,
   input  logic        cmd_wide,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_sel,
   output logic        alu_cin,
   input  logic [31:0] alu_y,
   input  logic        alu_cout,
   input  logic        alu_neg,
   input  logic        alu_zero,
   input  logic        alu_ovf,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_y,
   output logic        rsp_cout,
   output logic        rsp_neg,
   output logic        rsp_zero,
   output logic        rsp_ovf,
   output logic [15:0] ops_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_accept;
   logic        w_drive;
   logic        w_cmd_wide;
   logic [31:0] w_drv_a;
   logic [31:0] w_drv_b;
   logic        w_drv_cin;

   logic [63:0] r_a;
   logic [63:0] r_b;
   logic [3:0]  r_sel;
   logic        r_cin;
   logic        r_wide;
   logic [15:0] r_ops_done;

`ifdef ALU_SEQ_WIDE_EN
   assign w_cmd_wide = cmd_wide;
`else
   logic w_unused_cmd_wide;
   assign w_unused_cmd_wide = cmd_wide;
   assign w_cmd_wide        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      rsp_valid   = 1'b0;
      w_drive     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_state_nxt = S_LO;
         end
         S_LO: begin
            w_drive     = 1'b1;
            w_state_nxt = r_wide ? S_HI : S_RESP;
         end
         S_HI: begin
            w_drive     = 1'b1;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = cmd_valid & cmd_ready;

   // The high pass chains on the carry captured (into rsp_cout) by the low pass.
   assign w_drv_a   = (r_state == S_HI) ? r_a[63:32] : r_a[31:0];
   assign w_drv_b   = (r_state == S_HI) ? r_b[63:32] : r_b[31:0];
   assign w_drv_cin = (r_state == S_HI) ? rsp_cout   : r_cin;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_sel      <= '0;
         r_cin      <= 1'b0;
         r_wide     <= 1'b0;
         rsp_y      <= '0;
         rsp_cout   <= 1'b0;
         rsp_neg    <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_ovf    <= 1'b0;
         r_ops_done <= '0;
      end else begin
         if (w_accept) begin
            r_a    <= cmd_a;
            r_b    <= cmd_b;
            r_sel  <= cmd_sel;
            r_cin  <= cmd_cin;
            r_wide <= w_cmd_wide;
         end
         if (r_state == S_LO) begin
            rsp_y    <= {32'h0, alu_y};
            rsp_cout <= alu_cout;
            rsp_neg  <= alu_neg;
            rsp_zero <= alu_zero;
            rsp_ovf  <= alu_ovf;
         end
         if (r_state == S_HI) begin
            rsp_y[63:32] <= alu_y;
            rsp_cout     <= alu_cout;
            rsp_neg      <= alu_neg;
            rsp_zero     <= rsp_zero & alu_zero;
            rsp_ovf      <= alu_ovf;
         end
         if (rsp_valid && rsp_ready) r_ops_done <= r_ops_done + 16'd1;
      end
   end

   assign ops_done = r_ops_done;

   generate
      if (ZERO_IDLE_DRIVE != 0) begin : g_idle_zero
         assign alu_a   = w_drive ? w_drv_a   : 32'h0;
         assign alu_b   = w_drive ? w_drv_b   : 32'h0;
         assign alu_sel = w_drive ? r_sel     : 4'h0;
         assign alu_cin = w_drive ? w_drv_cin : 1'b0;
      end else begin : g_idle_hold
         logic [31:0] r_hold_a;
         logic [31:0] r_hold_b;
         logic [3:0]  r_hold_sel;
         logic        r_hold_cin;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_hold_a   <= '0;
               r_hold_b   <= '0;
               r_hold_sel <= '0;
               r_hold_cin <= 1'b0;
            end else if (w_drive) begin
               r_hold_a   <= w_drv_a;
               r_hold_b   <= w_drv_b;
               r_hold_sel <= r_sel;
               r_hold_cin <= w_drv_cin;
            end
         end
         assign alu_a   = w_drive ? w_drv_a   : r_hold_a;
         assign alu_b   = w_drive ? w_drv_b   : r_hold_b;
         assign alu_sel = w_drive ? r_sel     : r_hold_sel;
         assign alu_cin = w_drive ? w_drv_cin : r_hold_cin;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// Bench for alu_op_sequencer: drives a behavioural ALU and checks every response
// against a whole-word (32- or 64-bit) arithmetic reference model.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_WIDE_EN
   localparam bit c_wide_en = 1'b1;
`else
   localparam bit c_wide_en = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_sel;
   logic [63:0] cmd_a;
   logic [63:0] cmd_b;
   logic        cmd_cin;
   logic        cmd_wide;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_sel;
   logic        alu_cin;
   logic [31:0] alu_y;
   logic        alu_cout;
   logic        alu_neg;
   logic        alu_zero;
   logic        alu_ovf;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_y;
   logic        rsp_cout;
   logic        rsp_neg;
   logic        rsp_zero;
   logic        rsp_ovf;
   logic [15:0] ops_done;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_ops  = '0;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_wide(cmd_wide),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
      .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
      .ops_done(ops_done)
   );

   // Downstream combinational ALU
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {32'h0, alu_cin};
      alu_y    = '0;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      case (alu_sel)
         4'b0000: alu_y = alu_a & alu_b;
         4'b0001: alu_y = alu_a | alu_b;
         4'b0100: alu_y = alu_a ^ alu_b;
         4'b0110: begin
            alu_y    = alu_sum[31:0];
            alu_cout = alu_sum[32];
            alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
         end
         default: ;
      endcase
      alu_neg  = alu_y[31];
      alu_zero = (alu_y == 32'h0);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Whole-word reference: one 32-bit or one 64-bit operation
   function automatic void ref_op(input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic [3:0] sel, input logic cin, input logic wide,
                                  output logic [63:0] y, output logic [3:0] flags);
      logic [63:0] a, b;
      logic [64:0] s;
      logic        c, n, z, o;
      int          msb;
      a   = wide ? a_in : {32'h0, a_in[31:0]};
      b   = wide ? b_in : {32'h0, b_in[31:0]};
      msb = wide ? 63 : 31;
      s   = {1'b0, a} + {1'b0, b} + {64'h0, cin};
      c = 1'b0;
      o = 1'b0;
      case (sel)
         4'b0000: y = a & b;
         4'b0001: y = a | b;
         4'b0100: y = a ^ b;
         default: begin
            y = wide ? s[63:0] : {32'h0, s[31:0]};
            c = wide ? s[64] : s[32];
            o = (a[msb] == b[msb]) && (y[msb] != a[msb]);
         end
      endcase
      n = y[msb];
      z = (y == 64'h0);
      flags = {c, n, z, o};
   endfunction

   task automatic randomize_cmd_fields();
      cmd_a    = {$urandom, $urandom};
      cmd_b    = {$urandom, $urandom};
      cmd_sel  = 4'($urandom);
      cmd_cin  = 1'($urandom);
      cmd_wide = 1'($urandom);
   endtask

   task automatic check_idle_drive(input string tag);
      check(tag, {63'h0, |{alu_a, alu_b, alu_sel, alu_cin}}, 64'h0);
   endtask

   task automatic run_cmd(input logic [63:0] a, input logic [63:0] b, input logic [3:0] sel,
                          input logic cin, input logic wide, input int hold);
      logic [63:0] ey, ylo;
      logic [3:0]  ef, flo;
      logic        ew;
      int          lat;
      ew = wide & c_wide_en;
      ref_op(a, b, sel, cin, ew, ey, ef);
      ref_op(a, b, sel, cin, 1'b0, ylo, flo);
      check("cmd_ready_idle", {63'h0, cmd_ready}, 64'h1);
      cmd_valid = 1'b1;
      cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_cin = cin; cmd_wide = wide;
      @(posedge clk); #1;
      cmd_valid = 1'($urandom);
      randomize_cmd_fields();
      lat = 1;
      check("alu_lo_ab", {alu_a, alu_b}, {a[31:0], b[31:0]});
      check("alu_lo_sel_cin", {59'h0, alu_sel, alu_cin}, {59'h0, sel, cin});
      while (!rsp_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 2 && ew) begin
            check("alu_hi_ab", {alu_a, alu_b}, {a[63:32], b[63:32]});
            check("alu_hi_cin", {63'h0, alu_cin}, {63'h0, flo[3]});
         end
      end
      check("latency", 64'(lat), ew ? 64'd3 : 64'd2);
      check("rsp_y", rsp_y, ey);
      check("rsp_flags", {60'h0, rsp_cout, rsp_neg, rsp_zero, rsp_ovf}, {60'h0, ef});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid_ready", {62'h0, rsp_valid, cmd_ready}, 64'h2);
         check("hold_rsp_y", rsp_y, ey);
         check("hold_flags", {60'h0, rsp_cout, rsp_neg, rsp_zero, rsp_ovf}, {60'h0, ef});
         cmd_valid = 1'($urandom);
         randomize_cmd_fields();
      end
      // Completion cycle with a competing command that must not be taken yet
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      randomize_cmd_fields();
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      exp_ops   = exp_ops + 16'd1;
      check("ops_done", {48'h0, ops_done}, {48'h0, exp_ops});
      check("post_valid_ready", {62'h0, rsp_valid, cmd_ready}, 64'h1);
      check_idle_drive("idle_alu_zero");
   endtask

   task automatic reset_midflight(input logic wide);
      cmd_valid = 1'b1;
      cmd_a = 64'h00000000FFFFFFFF; cmd_b = 64'h1; cmd_sel = 4'b0110; cmd_cin = 1'b0; cmd_wide = wide;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (wide && c_wide_en) begin
         @(posedge clk); #1;
         check("rst_pre_hi_cin", {63'h0, alu_cin}, 64'h1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ops = '0;
      check("rst_valid_ready", {62'h0, rsp_valid, cmd_ready}, 64'h1);
      check("rst_ops", {48'h0, ops_done}, {48'h0, exp_ops});
      check_idle_drive("rst_alu_zero");
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_no_rsp", {63'h0, rsp_valid}, 64'h0);
      end
      check("rst_ops_later", {48'h0, ops_done}, {48'h0, exp_ops});
   endtask

   initial begin
      logic [3:0] sels [4];
      sels[0] = 4'b0000; sels[1] = 4'b0001; sels[2] = 4'b0100; sels[3] = 4'b0110;
      rst = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_cin = 1'b0; cmd_wide = 1'b0;
      @(posedge clk); #1;
      check("reset_valid_ready", {62'h0, rsp_valid, cmd_ready}, 64'h1);
      check("reset_rsp_y", rsp_y, 64'h0);
      check("reset_flags", {60'h0, rsp_cout, rsp_neg, rsp_zero, rsp_ovf}, 64'h0);
      check("reset_ops", {48'h0, ops_done}, 64'h0);
      check_idle_drive("reset_alu_zero");
      rst = 1'b0;
      @(posedge clk); #1;

      reset_midflight(1'b1);

      run_cmd(64'hF0F0F0F0, 64'hFF00FF00, 4'b0000, 1'b0, 1'b0, 0);
      check("and_const_y", rsp_y, 64'h00000000F000F000);
      run_cmd(64'h00000000FFFFFFFF, 64'h1, 4'b0110, 1'b0, 1'b1, 0);
      run_cmd(64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 4'b0100, 1'b1, 1'b1, 5);

      for (int k = 0; k < 40; k++)
         run_cmd({$urandom, $urandom}, {$urandom, $urandom}, sels[$urandom_range(0, 3)],
                 1'($urandom), 1'($urandom), $urandom_range(0, 3));

      // Counter wrap: preset to the top value, then complete one more
      force dut.r_ops_done = 16'hFFFF;
      @(posedge clk); #1;
      release dut.r_ops_done;
      exp_ops = 16'hFFFF;
      check("ops_preset", {48'h0, ops_done}, {48'h0, exp_ops});
      run_cmd(64'hFFFFFFFF, 64'h1, 4'b0110, 1'b0, 1'b1, 0);
      check("ops_wrapped", {48'h0, ops_done}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
